instr_fetch: RTL

- Upstream stage of the single-cycle control decoder.
- Owns the PC, issues word reads to instruction memory over a req/ack handshake, and holds the fetched word steady on `instruction` until the decoder side accepts it.
- On acceptance, consumes the decoder's `is_jump`/`is_branch`/`addr26`/`imm16` outputs plus the datapath's `branch_taken` to compute the next PC.

---
 rtl/instr_fetch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads one word at a time from
// instruction memory over a req/ack handshake and holds the fetched word
// for the decoder until it is accepted.
//
// Handshakes:
//   memory side  - mem_req stays high with a constant mem_addr until mem_ack
//                  is seen; one outstanding request at most, and mem_ack is
//                  ignored whenever no request is open.
//   decoder side - instr_valid/instruction stay stable until instr_ready is
//                  high on a clock edge while instr_valid is high; that edge
//                  transfers the word and advances the PC.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        is_jump,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic [25:0] addr26,
    input  logic [15:0] imm16,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // The wait counter only ever needs to reach MEM_TIMEOUT-1.
    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST  = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic          TIMEOUT_ON = (MEM_TIMEOUT != 0);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    logic [31:0]   branch_off;
    logic [31:0]   next_pc;

    assign mem_addr = pc;

    // Timeout fires on the MEM_TIMEOUT-th request cycle that still has no ack.
    assign timeout_hit = TIMEOUT_ON && (state == S_REQ) && !mem_ack && (wait_cnt == WAIT_LAST);

    // Next-PC selection: jump beats taken branch beats sequential.
    always_comb begin
        pc_plus4   = pc + 32'd4;
        branch_off = {{14{imm16[15]}}, imm16, 2'b00};
        next_pc    = pc_plus4;
        if (is_jump) begin
            next_pc = {pc_plus4[31:28], addr26, 2'b00};
        end else if (is_branch && branch_taken) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RST;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and request output; mem_req follows the state so reset drops it at once.
    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        case (state)
            S_RST: begin
                state_nx = S_REQ;
            end
            S_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nx = S_HOLD;
                end else if (timeout_hit) begin
                    state_nx = S_ERR;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_nx = S_REQ;
                end
            end
            S_ERR: begin
                state_nx = S_ERR;
            end
            default: begin
                state_nx = S_RST;
            end
        endcase
    end

    // Datapath registers: PC, held word, valid flag, wait counter and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instruction <= 32'h0;
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (mem_ack) begin
                        instruction <= mem_rdata;
                        instr_valid <= 1'b1;
                        wait_cnt    <= '0;
                    end else if (timeout_hit) begin
                        fetch_err <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= next_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
